// File: rtl/led_pio_write_arbiter_if.sv
// led_pio_write_arbiter_if: requester handshake plus Avalon-MM PIO master signals of the LED write arbiter
interface led_pio_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [1:0]                m_address;
    logic                      m_chipselect;
    logic                      m_write_n;
    logic [31:0]               m_writedata;
    logic [31:0]               m_readdata;
    logic                      verify_err;

    modport master (
        input  req, req_data, m_readdata,
        output ack, grant_id, busy, m_address, m_chipselect, m_write_n, m_writedata, verify_err
    );

    modport slave (
        output req, req_data, m_readdata,
        input  ack, grant_id, busy, m_address, m_chipselect, m_write_n, m_writedata, verify_err
    );
endinterface

// File: rtl/led_pio_write_arbiter.sv
// led_pio_write_arbiter: round-robin sharing of one LED PIO data register; LED_ARB_VERIFY_EN adds a readback check cycle
module led_pio_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int MIN_GAP = 2
) (
    input logic clk,
    input logic reset_n,
    led_pio_write_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = $clog2(MIN_GAP + 2);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP > 0 ? MIN_GAP - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
`ifdef LED_ARB_VERIFY_EN
        VERIFY,
`endif
        GAP
    } state_t;

    localparam state_t AFTER = (MIN_GAP > 0) ? GAP : IDLE;

    state_t              state, state_nx;
    logic [PW-1:0]       ptr, ptr_nx, sel, gid, gid_nx;
    logic                hit, arb;
    logic [DATA_W-1:0]   data_q, data_nx;
    logic [GW-1:0]       cnt, cnt_nx;
    logic                cs, cs_nx, wn, wn_nx, busy_q;
    logic [NUM_REQ-1:0]  ack_q, ack_nx;
`ifdef LED_ARB_VERIFY_EN
    logic                err, err_nx;
`endif

    function automatic logic [PW-1:0] wrap(input int i);
        return PW'(i >= NUM_REQ ? i - NUM_REQ : i);
    endfunction

    // the last GAP cycle arbitrates like IDLE so grants are spaced 1+MIN_GAP apart
    assign arb = (state == IDLE) || (state == GAP && cnt == '0);

    // rotating priority search: first set request at or above the pointer, wrapping
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[wrap(int'(ptr) + k)]) begin
                hit = 1'b1;
                sel = wrap(int'(ptr) + k);
            end
        end
    end

    // next state and next registered outputs
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        data_nx  = data_q;
        gid_nx   = gid;
        cnt_nx   = cnt;
        cs_nx    = 1'b0;
        wn_nx    = 1'b1;
        ack_nx   = '0;
`ifdef LED_ARB_VERIFY_EN
        err_nx   = err;
`endif
        if (arb) begin
            state_nx = hit ? WRITE : IDLE;
            if (hit) begin
                ptr_nx  = wrap(int'(sel) + 1);
                data_nx = bus.req_data[int'(sel)*DATA_W +: DATA_W];
                gid_nx  = sel;
                cs_nx   = 1'b1;
                wn_nx   = 1'b0;
`ifndef LED_ARB_VERIFY_EN
                ack_nx  = ONE << sel;
`endif
            end
        end else if (state == WRITE) begin
`ifdef LED_ARB_VERIFY_EN
            state_nx = VERIFY;
            cs_nx    = 1'b1;
            ack_nx   = ONE << gid;
`else
            state_nx = AFTER;
            cnt_nx   = GAP_LOAD;
`endif
        end
`ifdef LED_ARB_VERIFY_EN
        else if (state == VERIFY) begin
            state_nx = AFTER;
            cnt_nx   = GAP_LOAD;
            err_nx   = err | (bus.m_readdata[DATA_W-1:0] != data_q);
        end
`endif
        else begin
            cnt_nx = cnt - 1'b1;
        end
    end

    // state and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            data_q <= '0;
            gid    <= '0;
            cnt    <= '0;
            cs     <= 1'b0;
            wn     <= 1'b1;
            ack_q  <= '0;
            busy_q <= 1'b0;
`ifdef LED_ARB_VERIFY_EN
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            data_q <= data_nx;
            gid    <= gid_nx;
            cnt    <= cnt_nx;
            cs     <= cs_nx;
            wn     <= wn_nx;
            ack_q  <= ack_nx;
            busy_q <= state_nx != IDLE;
`ifdef LED_ARB_VERIFY_EN
            err    <= err_nx;
`endif
        end
    end

    assign bus.ack          = ack_q;
    assign bus.grant_id     = 3'(gid);
    assign bus.busy         = busy_q;
    assign bus.m_address    = 2'b00;
    assign bus.m_chipselect = cs;
    assign bus.m_write_n    = wn;
    assign bus.m_writedata  = 32'(data_q);
`ifdef LED_ARB_VERIFY_EN
    assign bus.verify_err   = err;
`else
    assign bus.verify_err   = 1'b0;
`endif
endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// tb_led_pio_write_arbiter: directed plus random requests against a queue-based model; define LED_ARB_VERIFY_EN for the readback build
`timescale 1ns/1ps
module tb_led_pio_write_arbiter;
    localparam int N = 4, W = 4, MIN_GAP = 2;
`ifdef LED_ARB_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    typedef struct {int cyc; int id; logic [W-1:0] data;} exp_t;

    logic         clk = 1'b0, reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [W-1:0] led;
    logic         corrupt = 1'b0;
    exp_t         exp_q[$];
    exp_t         cur;
    int           c = 0, ptr = 0, next_arb = 0, last_grant = -100;
    int           drop_at[N];
    int           drop_delay = 2 + V;
    bit           rnd = 0, auto_drop = 1, run = 0, vpend = 0, exp_err = 0;
    int           nchk = 0, nfail = 0;

    led_pio_write_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    led_pio_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.req        = req;
    assign bus.req_data   = req_data;
    assign bus.m_readdata = corrupt ? 32'h0 : 32'(led);

    // PIO data register model
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) led <= '0;
        else if (bus.m_chipselect && !bus.m_write_n) led <= bus.m_writedata[W-1:0];
    end

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", n, a, e, c);
        end
    endfunction

    // one clock: arbitrate in the model at the edge, then update requesters
    task automatic step();
        int g;
        @(posedge clk);
        c++;
        g = -1;
        if (c >= next_arb && req != '0) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && req[(ptr + k) % N]) g = (ptr + k) % N;
            exp_q.push_back('{cyc: c, id: g, data: req_data[g*W +: W]});
            ptr        = (g + 1) % N;
            next_arb   = c + 1 + MIN_GAP + V;
            last_grant = c;
            drop_at[g] = auto_drop ? c + (rnd ? int'($urandom_range(0, 2 + V)) : drop_delay) : -1;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            if (drop_at[i] == c) begin
                req[i] = 1'b0;
                drop_at[i] = -1;
            end else if (rnd && drop_at[i] < 0) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*W +: W] = W'($urandom);
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_cs", 32'(bus.m_chipselect), 0);
        chk("rst_write_n", 32'(bus.m_write_n), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_writedata", bus.m_writedata, 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_address", 32'(bus.m_address), 0);
        chk("rst_verify_err", 32'(bus.verify_err), 0);
    endtask

    // asynchronous reset in the middle of the current cycle
    task automatic hit_reset();
        #2 reset_n = 1'b0;
        run = 0;
        #1 chk_reset_vals();
        req = '0;
        exp_q.delete();
        ptr = 0;
        next_arb = 0;
        last_grant = -100;
        exp_err = 0;
        foreach (drop_at[i]) drop_at[i] = -1;
        @(negedge clk);
        #1 reset_n = 1'b1;
        run = 1;
    endtask

    // monitor: every cycle checks busy/verify_err/ack and pops on each write strobe
    always @(negedge clk) begin
        if (!run) begin
            vpend = 0;
        end else begin
            chk("busy", 32'(bus.busy), 32'((c - last_grant) <= MIN_GAP + V));
            chk("verify_err", 32'(bus.verify_err), 32'(exp_err));
            if (exp_q.size() > 0 && c > exp_q[0].cyc + 4) begin
                nfail++;
                $display("FAIL write_timeout actual=none required=write of id %0d by cycle %0d", exp_q[0].id, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.m_chipselect && !bus.m_write_n) begin
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_write actual=%h required=no write (cycle %0d)", bus.m_writedata, c);
                end else begin
                    cur = exp_q.pop_front();
                    chk("write_cycle", 32'(c), 32'(cur.cyc));
                    chk("writedata", bus.m_writedata, 32'(cur.data));
                    chk("address", 32'(bus.m_address), 0);
                    chk("grant_id", 32'(bus.grant_id), 32'(cur.id));
                    chk("ack_write", 32'(bus.ack), V ? 32'h0 : 32'(1 << cur.id));
                    vpend = (V == 1);
                end
            end else if (vpend) begin
                chk("verify_strobe", 32'({bus.m_chipselect, bus.m_write_n}), 32'h3);
                chk("ack_verify", 32'(bus.ack), 32'(1 << cur.id));
                exp_err = exp_err | (bus.m_readdata[W-1:0] != cur.data);
                vpend = 0;
            end else begin
                chk("ack_idle", 32'(bus.ack), 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (drop_at[i]) drop_at[i] = -1;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals();
        reset_n = 1'b1;
        run = 1;
        // single request from requester 0
        req = 4'b0001;
        req_data[3:0] = 4'hA;
        repeat (6) step();
        // all four held: strict rotation with distinct data
        auto_drop = 0;
        req_data = 16'h4321;
        req = 4'b1111;
        repeat (16) step();
        req = '0;
        auto_drop = 1;
        repeat (5) step();
        // serve 1 alone so the pointer sits at 2, then 0 and 1 together
        req = 4'b0010;
        repeat (6) step();
        req = 4'b0011;
        repeat (10) step();
        req = '0;
        repeat (4) step();
        // request dropped during its write cycle
        drop_delay = 0;
        req = 4'b0100;
        repeat (6) step();
        drop_delay = 2 + V;
        // reset during the write cycle, then during the gap
        req = 4'b0100;
        step();
        hit_reset();
        req = 4'b0110;
        repeat (10) step();
        req = 4'b0001;
        repeat (3) step();
        hit_reset();
        req = 4'b1100;
        repeat (10) step();
        req = '0;
        repeat (3) step();
        // corrupted readback, then a clean access
        corrupt = 1'b1;
        req_data[3:0] = 4'h5;
        req = 4'b0001;
        repeat (6) step();
        corrupt = 1'b0;
        req_data[7:4] = 4'h7;
        req = 4'b0010;
        repeat (6) step();
        // random traffic
        rnd = 1;
        repeat (2000) step();
        rnd = 0;
        req = '0;
        repeat (12) step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
